d_ff_pipe: RTL and testbench
============================

D_FF_PIPE -- requirements
Module: d_ff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..16.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port en  input  1  advance enable; 1 shifts the pipe one stage, 0 holds every stage.
REQ-006 Port d  input  WIDTH  data into stage 0.
REQ-007 Port d_valid  input  1  marks d as a valid entry.
REQ-008 Port q  output  WIDTH  data of stage DEPTH-1, registered.
REQ-009 Port q_valid  output  1  valid bit of stage DEPTH-1, registered.
REQ-010 Port count  output  CW  number of valid stages; CW = clog2(DEPTH+1).
REQ-011 Port full  output  1  1 when count == DEPTH.
REQ-012 Port flush  input  1  present only when D_FF_PIPE_FLUSH_EN is defined; see Configuration.

Function
REQ-013 Each stage holds a WIDTH-bit data register and a 1-bit valid register.
REQ-014 On a rising edge with en=1, stage 0 takes d and d_valid, and stage i takes stage i-1 for i = 1..DEPTH-1.
REQ-015 On a rising edge with en=0, every data, valid and count register holds its value.
REQ-016 Data registers shift with en regardless of valid bits; the valid bits only qualify the data.
REQ-017 Latency is DEPTH enabled edges: d sampled at enabled edge k appears on q after enabled edge k+DEPTH-1.
REQ-018 Disabled edges between enabled edges do not count toward latency.
REQ-019 With DEPTH=1, q and q_valid equal the values sampled at the last enabled edge.
REQ-020 count is registered. On an enabled edge it updates to count + d_valid - q_valid, where q_valid is the value before the edge. Simultaneous entry and exit leave count unchanged.
REQ-021 count never exceeds DEPTH and never underflows; with en=0 it holds.
REQ-022 full is combinational from count and carries no extra register stage.
REQ-023 Entering a valid item while full=1 and en=1 is legal: the oldest entry leaves on q in the same edge and count stays DEPTH.

Reset
REQ-024 Assertion of rst_n=0 immediately clears all data registers to 0, all valid bits to 0 and count to 0, independent of clk.
REQ-025 While rst_n=0, outputs read q=0, q_valid=0, count=0 and full=0 (full=1 when DEPTH=0 is excluded by REQ-002).
REQ-026 Reset asserted mid-stream discards all in-flight entries.
REQ-027 The first enabled edge after rst_n deassertion behaves per REQ-014.

Configuration
REQ-028 Macro D_FF_PIPE_FLUSH_EN, when defined, adds the flush input.
REQ-029 flush=1 at a rising edge clears all valid bits and count to 0 synchronously and leaves data registers unchanged.
REQ-030 flush has priority over en: a flush edge does not shift and does not capture d_valid.
REQ-031 Without D_FF_PIPE_FLUSH_EN there is no flush port and no flush logic; behaviour is REQ-013..REQ-027 only.

Verification (WIDTH=8, DEPTH=4)
REQ-032 Reset, then en=1 and d=0x11,0x22,0x33,0x44 with d_valid=1 on 4 edges -> q=0x11 and q_valid=1 after the 4th edge; count=4 and full=1.
REQ-033 Drop en=0 for 3 edges while d changes -> q, q_valid and count are frozen. With en=1 again, 0x22 appears on the next edge.
REQ-034 Full pipe with d_valid=1 on each enabled edge -> count stays 4. Then d_valid=0 for 4 edges -> count steps 3,2,1,0 and q_valid falls after the last valid entry leaves.
REQ-035 Assert rst_n=0 between clock edges with count=3 -> q=0, q_valid=0 and count=0 immediately, with no clock edge needed.
REQ-036 D_FF_PIPE_FLUSH_EN defined, count=3, flush=1 and en=1 with d_valid=1 on one edge -> count=0 and q_valid=0, and q data is unchanged from before the edge.
REQ-037 DEPTH=1 build: d=0xA5 and d_valid=1 on one enabled edge -> q=0xA5, q_valid=1 and count=1 after that edge.

Source files
------------

// File: rtl/d_ff_pipe.sv
// Enable-gated shift pipeline of DEPTH data/valid stages with a registered occupancy count.
// Optional synchronous flush of valid bits and count when D_FF_PIPE_FLUSH_EN is defined.
module d_ff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
`ifdef D_FF_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic             valid_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             shift_en;
  logic             clear_valid;

`ifdef D_FF_PIPE_FLUSH_EN
  // Flush wins over en: no shift and no capture of d_valid on a flush edge.
  assign clear_valid = flush;
  assign shift_en    = en & ~flush;
`else
  assign clear_valid = 1'b0;
  assign shift_en    = en;
`endif

  // One valid enters, the oldest leaves; modulo arithmetic nets out correctly at DEPTH.
  always_comb begin
    count_d = count_q + CW'(d_valid) - CW'(valid_q[DEPTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
      count_q <= '0;
    end else if (clear_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
      end
      count_q <= '0;
    end else if (shift_en) begin
      data_q[0]  <= d;
      valid_q[0] <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
      count_q <= count_d;
    end
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = valid_q[DEPTH-1];
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_d_ff_pipe.sv
// Directed bench for d_ff_pipe: a DEPTH=4 instance and a DEPTH=1 instance sharing clock and reset.
// The flush step is compiled in only when D_FF_PIPE_FLUSH_EN is defined.
module tb_d_ff_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, d_valid;
  logic [7:0] d;
  logic [7:0] q;
  logic       q_valid, full;
  logic [2:0] count;
`ifdef D_FF_PIPE_FLUSH_EN
  logic       flush;
`endif

  logic       en1, d_valid1;
  logic [7:0] d1, q1;
  logic       q_valid1, full1;
  logic [0:0] count1;
`ifdef D_FF_PIPE_FLUSH_EN
  logic       flush1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_ff_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .d_valid(d_valid),
`ifdef D_FF_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .q(q), .q_valid(q_valid), .count(count), .full(full)
  );

  d_ff_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .d(d1), .d_valid(d_valid1),
`ifdef D_FF_PIPE_FLUSH_EN
    .flush(flush1),
`endif
    .q(q1), .q_valid(q_valid1), .count(count1), .full(full1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic e, input logic dv, input logic [7:0] dd);
    en = e; d_valid = dv; d = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [7:0] eq, input logic eqv,
                      input logic [2:0] ecnt, input logic efull);
    chk({tag, ".q"},     64'(q),       64'(eq));
    chk({tag, ".qv"},    64'(q_valid), 64'(eqv));
    chk({tag, ".count"}, 64'(count),   64'(ecnt));
    chk({tag, ".full"},  64'(full),    64'(efull));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; d_valid = 1'b0; d = 8'h00;
    en1 = 1'b0; d_valid1 = 1'b0; d1 = 8'h00;
`ifdef D_FF_PIPE_FLUSH_EN
    flush = 1'b0; flush1 = 1'b0;
`endif
    #3;
    chk4("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    chk("reset1.q", 64'(q1), 64'h0);
    chk("reset1.count", 64'(count1), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill four valid entries; the first arrives on q after the 4th edge.
    step(1'b1, 1'b1, 8'h11);
    chk4("fill1", 8'h00, 1'b0, 3'd1, 1'b0);
    step(1'b1, 1'b1, 8'h22);
    step(1'b1, 1'b1, 8'h33);
    chk4("fill3", 8'h00, 1'b0, 3'd3, 1'b0);
    step(1'b1, 1'b1, 8'h44);
    chk4("fill4", 8'h11, 1'b1, 3'd4, 1'b1);

    // Hold with en=0 while d changes.
    step(1'b0, 1'b1, 8'h55);
    chk4("hold1", 8'h11, 1'b1, 3'd4, 1'b1);
    step(1'b0, 1'b0, 8'h66);
    step(1'b0, 1'b1, 8'h77);
    chk4("hold3", 8'h11, 1'b1, 3'd4, 1'b1);
    step(1'b1, 1'b1, 8'h55);
    chk4("resume", 8'h22, 1'b1, 3'd4, 1'b1);

    // Full pipe, simultaneous entry and exit.
    step(1'b1, 1'b1, 8'h66);
    chk4("fullin", 8'h33, 1'b1, 3'd4, 1'b1);

    // Drain; data still shifts while d_valid=0.
    step(1'b1, 1'b0, 8'h99);
    chk4("drain1", 8'h44, 1'b1, 3'd3, 1'b0);
    step(1'b1, 1'b0, 8'h99);
    chk4("drain2", 8'h55, 1'b1, 3'd2, 1'b0);
    step(1'b1, 1'b0, 8'h99);
    chk4("drain3", 8'h66, 1'b1, 3'd1, 1'b0);
    step(1'b1, 1'b0, 8'h99);
    chk4("drain4", 8'h99, 1'b0, 3'd0, 1'b0);

    // Asynchronous reset mid-stream with count=3.
    step(1'b1, 1'b1, 8'hA1);
    step(1'b1, 1'b1, 8'hA2);
    step(1'b1, 1'b1, 8'hA3);
    chk4("pre_rst", 8'h99, 1'b0, 3'd3, 1'b0);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst", 8'h00, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b1, 8'hC1);
    chk4("post_rst", 8'h00, 1'b0, 3'd1, 1'b0);

`ifdef D_FF_PIPE_FLUSH_EN
    // Bring count to 3 with a non-zero entry on q, then flush.
    step(1'b1, 1'b1, 8'hB1);
    step(1'b1, 1'b1, 8'hB2);
    step(1'b1, 1'b1, 8'hB3);
    chk4("pre_flush", 8'hC1, 1'b1, 3'd4, 1'b1);
    step(1'b1, 1'b0, 8'hC0);
    chk4("pre_flush3", 8'hB1, 1'b1, 3'd3, 1'b0);
    flush = 1'b1;
    step(1'b1, 1'b1, 8'hDD);
    flush = 1'b0;
    chk4("flush", 8'hB1, 1'b0, 3'd0, 1'b0);
`endif

    // DEPTH=1 instance.
    en1 = 1'b1; d_valid1 = 1'b1; d1 = 8'hA5;
    @(posedge clk);
    #1;
    chk("d1.q", 64'(q1), 64'hA5);
    chk("d1.qv", 64'(q_valid1), 64'h1);
    chk("d1.count", 64'(count1), 64'h1);
    chk("d1.full", 64'(full1), 64'h1);
    en1 = 1'b0; d1 = 8'h3C; d_valid1 = 1'b0;
    @(posedge clk);
    #1;
    chk("d1.hold.q", 64'(q1), 64'hA5);
    en1 = 1'b1;
    @(posedge clk);
    #1;
    chk("d1.out.q", 64'(q1), 64'h3C);
    chk("d1.out.count", 64'(count1), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
